// File: rtl/datapath_control_unit.sv
// Hardwired Moore controller for the single-bus datapath: fetch (T0-T2) then decode/execute (T3-T5).
// ALU instruction takes 6 cycles, nop/illegal/halt 4; T1 stalls on mem_ready=0 with its strobes held.
module datapath_control_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             stop,
   input  logic [31:0]      ir,
   input  logic             mem_ready,
   output logic             PCout,
   output logic             PCin,
   output logic             IncPC,
   output logic             MARin,
   output logic             Zin,
   output logic             Zlowout,
   output logic             Read,
   output logic             MDRin,
   output logic             MDRout,
   output logic             IRin,
   output logic             Yin,
   output logic             Gra,
   output logic             Grb,
   output logic             Grc,
   output logic             Rin,
   output logic             Rout,
   output logic [3:0]       alu_op,
   output logic             run,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_HALT = 3'd7
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [4:0] opcode;
   logic       is_alu;
   logic       is_halt;
   logic       is_illegal;
   logic [3:0] dec_op;
   logic       retire;

   // Register fields are consumed by the external select/encode block, not here.
   logic       unused_ir_fields;

   assign opcode           = ir[31:27];
   assign unused_ir_fields = ^ir[26:0];

   always_comb begin
      is_alu     = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      dec_op     = 4'b0000;
      case (opcode)
         5'b00011: begin is_alu = 1'b1; dec_op = 4'b0001; end
         5'b00100: begin is_alu = 1'b1; dec_op = 4'b0010; end
         5'b00101: begin is_alu = 1'b1; dec_op = 4'b0011; end
         5'b00110: begin is_alu = 1'b1; dec_op = 4'b0100; end
         5'b00111: begin is_alu = 1'b1; dec_op = 4'b0101; end
         5'b01000: begin is_alu = 1'b1; dec_op = 4'b0110; end
         5'b11010: ;
         5'b11011: is_halt = 1'b1;
         default:  is_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   if (mem_ready) state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3: begin
            if (is_alu) begin
               state_d = S_T4;
            end else if (is_halt) begin
               // Halt beats a concurrent stop request.
               retire  = 1'b1;
               state_d = S_HALT;
            end else begin
               retire  = 1'b1;
               state_d = stop ? S_IDLE : S_T0;
            end
         end
         S_T4:   state_d = S_T5;
         S_T5: begin
            retire  = 1'b1;
            state_d = stop ? S_IDLE : S_T0;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      count_d = retire ? count_q + CNT_W'(1) : count_q;
   end

   always_comb begin
      PCout   = 1'b0;
      PCin    = 1'b0;
      IncPC   = 1'b0;
      MARin   = 1'b0;
      Zin     = 1'b0;
      Zlowout = 1'b0;
      Read    = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      Gra     = 1'b0;
      Grb     = 1'b0;
      Grc     = 1'b0;
      Rin     = 1'b0;
      Rout    = 1'b0;
      alu_op  = 4'b0000;
      run     = 1'b0;
      halted  = 1'b0;
      illegal = 1'b0;
      case (state_q)
         S_T0: begin
            run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
         end
         S_T1: begin
            // Z is untouched during a stall, so holding PCin is harmless.
            run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         S_T2: begin
            run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
         end
         S_T3: begin
            run     = 1'b1;
            illegal = is_illegal;
            if (is_alu) begin
               Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            end
         end
         S_T4: begin
            run = 1'b1; Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = dec_op;
         end
         S_T5: begin
            run = 1'b1; Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
         end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   assign instr_count = count_q;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

endmodule

// File: doc/datapath_control_unit.md
Name: datapath_control_unit

Overview:
- Hardwired Moore controller that sequences the single-bus datapath through instruction fetch and register-register ALU execution.
- Replaces hand-driven control strobes (PCout, Zlowout, MDRin, IRin, Yin, Rin/Rout, ALU select) with T-state generation decoded from IR.
- Sits beside the datapath. A separate select/encode block maps Gra/Grb/Grc plus Rin/Rout onto the individual register enables.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock, all state changes on rising edge
- clear  input  1  asynchronous, active-low reset
- start  input  1  leave IDLE and begin fetching (level, sampled in IDLE)
- stop  input  1  request pause at next instruction boundary (level)
- ir  input  32  instruction register contents from datapath
- mem_ready  input  1  memory read data valid this cycle
- PCout, PCin, IncPC, MARin, Zin, Zlowout  output  1 each  datapath bus/register strobes
- Read, MDRin, MDRout, IRin, Yin  output  1 each  memory/IR/Y strobes
- Gra, Grb, Grc, Rin, Rout  output  1 each  register-field select and general-register enables
- alu_op  output  4  ALU function select
- run  output  1  high in every fetch/execute state
- halted  output  1  high in HALT
- illegal  output  1  one-cycle pulse in T3 for an undefined opcode
- instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT. All outputs except instr_count are decoded combinationally from state and ir.
- Reset (clear=0, asynchronous): state=IDLE, instr_count=0. All strobes, alu_op, run, halted and illegal are 0. A reset mid-instruction abandons that instruction; no partial count.
- IDLE: all strobes 0. start=1 -> T0 next edge, otherwise stay.
- T0: PCout, MARin, IncPC, Zin. -> T1.
- T1: Zlowout, PCin, Read, MDRin held high. Stay while mem_ready=0; mem_ready=1 -> T2. PC update is idempotent across a stall because Z is unchanged.
- T2: MDRout, IRin. -> T3. IR is valid from T3.
- Decode, ir[31:27] opcode; ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]:
  - 00011 add -> alu_op 0001
  - 00100 sub -> 0010
  - 00101 and -> 0011
  - 00110 or -> 0100
  - 00111 shr -> 0101
  - 01000 shl -> 0110
  - 11010 nop
  - 11011 halt
  - all other opcodes are illegal
- T3, ALU op: Grb, Rout, Yin. -> T4.
- T3, nop or illegal: no strobes; illegal=1 if undefined. Instruction retires; go to boundary.
- T3, halt: -> HALT; instruction counts as retired.
- T4: Grc, Rout, alu_op=decoded value, Zin. -> T5.
- T5: Zlowout, Gra, Rin. Instruction retires; go to boundary.
- alu_op=0000 in every state other than T4.
- Boundary: instr_count increments on the retiring edge. Then -> IDLE if stop=1, else T0.
- stop is sampled only at the boundary. start in non-IDLE states is ignored.
- HALT: halted=1, run=0, all strobes 0. Exits only via clear; start and stop are ignored.
- run=1 in T0..T5, 0 in IDLE/HALT.
- Latency: ALU instruction takes 6 cycles at mem_ready=1, plus 1 per stall cycle. nop/illegal takes 4 cycles.
- Simultaneous stop and halt opcode: HALT wins.
- mem_ready outside T1 is ignored.
- Exactly one of Gra/Grb/Grc is high when Rin or Rout is high; none otherwise.

Test Plan:
- Reset/idle: clear low mid-T4 -> state IDLE immediately; all strobes 0, instr_count=0. Release clear with start=0 for 5 cycles -> still IDLE, run=0.
- AND R1,R2,R3: start=1, mem_ready=1, ir=0x28918000 loaded by T2 -> T3 {Grb,Rout,Yin}, T4 {Grc,Rout,Zin, alu_op=0011}, T5 {Zlowout,Gra,Rin}. instr_count=1 after 6 cycles.
- Memory stall: mem_ready=0 for 3 cycles in T1 -> Read/MDRin/PCin/Zlowout held for 4 cycles total. T2 follows on the first mem_ready=1 cycle; ADD (0x18918000) gives alu_op=0001 in T4.
- nop 0xD0000000 then illegal 0xF8000000 -> each takes 4 cycles with no register strobes. illegal pulses once in the second T3; instr_count advances by 2.
- Halt: ir=0xD8000000 with stop=1 -> HALT (not IDLE), halted=1, instr_count+1. start pulses are ignored; only clear exits.
- Stop/restart and wrap: stop=1 raised during T4 -> completes T5 then IDLE. start resumes at T0. With CNT_W=4, 16 retirements -> instr_count wraps to 0.
